// File: rtl/xillybus_lite_regbank_if.sv
// AXI4-Lite channel bundle between the xillybus PS wrapper and the register bank.
// Master drives addresses/data/response-ready; slave drives ready/response.
interface xillybus_lite_regbank_if #(
    parameter int C_S_AXI_ADDR_WIDTH = 32
);
    logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR;
    logic                          S_AXI_AWVALID;
    logic                          S_AXI_AWREADY;
    logic [31:0]                   S_AXI_WDATA;
    logic [3:0]                    S_AXI_WSTRB;
    logic                          S_AXI_WVALID;
    logic                          S_AXI_WREADY;
    logic [1:0]                    S_AXI_BRESP;
    logic                          S_AXI_BVALID;
    logic                          S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR;
    logic                          S_AXI_ARVALID;
    logic                          S_AXI_ARREADY;
    logic [31:0]                   S_AXI_RDATA;
    logic [1:0]                    S_AXI_RRESP;
    logic                          S_AXI_RVALID;
    logic                          S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
        output S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
        input  S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/xillybus_lite_regbank.sv
// AXI4-Lite register bank: RW control words, W1C interrupt status, IRQ enable.
// Write and read channels run independent two-state FSMs.
module xillybus_lite_regbank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_DECODE_BITS      = 9,
    parameter int C_NUM_REGS         = 8,
    parameter int C_NUM_IRQ          = 4,
    parameter bit C_USE_WSTRB        = 1'b1
) (
    input  logic                     S_AXI_ACLK,
    input  logic                     S_AXI_ARESETN,
    xillybus_lite_regbank_if.slave   s_axi,
    input  logic [C_NUM_IRQ-1:0]     irq_in,
    output logic [32*C_NUM_REGS-1:0] regs_out,
    output logic                     Interrupt
);
    localparam int IW = C_DECODE_BITS - 2;
    localparam logic [IW-1:0] STAT_IDX = IW'(C_NUM_REGS);
    localparam logic [IW-1:0] EN_IDX   = IW'(C_NUM_REGS + 1);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic [31:0]          regs [C_NUM_REGS];
    logic [C_NUM_IRQ-1:0] irq_status;
    logic [C_NUM_IRQ-1:0] irq_enable;

    logic [0:0]  w_state;
    logic [0:0]  r_state;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        rvalid;
    logic [1:0]  rresp;
    logic [31:0] rdata;

    logic          wr_fire;
    logic          rd_fire;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic          wr_map;
    logic [31:0]   wmask;
    logic [31:0]   wbits;
    logic [C_NUM_IRQ-1:0] w1c;
    logic [31:0]   rd_word;
    logic          rd_ok;
    logic          unused_sig;

    assign unused_sig = ^{s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR};

    // Accept address+data together, only when both are present.
    assign wr_fire = S_AXI_ARESETN && (w_state == W_IDLE) &&
                     s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
    assign rd_fire = S_AXI_ARESETN && (r_state == R_IDLE) &&
                     s_axi.S_AXI_ARVALID;

    assign s_axi.S_AXI_AWREADY = wr_fire;
    assign s_axi.S_AXI_WREADY  = wr_fire;
    assign s_axi.S_AXI_ARREADY = rd_fire;
    assign s_axi.S_AXI_BVALID  = bvalid;
    assign s_axi.S_AXI_BRESP   = bresp;
    assign s_axi.S_AXI_RVALID  = rvalid;
    assign s_axi.S_AXI_RRESP   = rresp;
    assign s_axi.S_AXI_RDATA   = rdata;

    assign wr_idx = s_axi.S_AXI_AWADDR[C_DECODE_BITS-1:2];
    assign rd_idx = s_axi.S_AXI_ARADDR[C_DECODE_BITS-1:2];
    assign wr_map = (wr_idx < EN_IDX) || (wr_idx == EN_IDX);

    // Byte-lane mask and masked write data; strobes bypassed when disabled.
    always_comb begin
        wmask = '1;
        if (C_USE_WSTRB) begin
            for (int b = 0; b < 4; b++) begin
                wmask[8*b +: 8] = {8{s_axi.S_AXI_WSTRB[b]}};
            end
        end
        wbits = s_axi.S_AXI_WDATA & wmask;
        w1c   = '0;
        if (wr_fire && wr_idx == STAT_IDX) begin
            w1c = wbits[C_NUM_IRQ-1:0];
        end
    end

    // Read mux over the current (pre-write) register contents.
    always_comb begin
        rd_word = '0;
        rd_ok   = 1'b0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (rd_idx == IW'(i)) begin
                rd_word = regs[i];
                rd_ok   = 1'b1;
            end
        end
        if (rd_idx == STAT_IDX) begin
            rd_word[C_NUM_IRQ-1:0] = irq_status;
            rd_ok                  = 1'b1;
        end
        if (rd_idx == EN_IDX) begin
            rd_word[C_NUM_IRQ-1:0] = irq_enable;
            rd_ok                  = 1'b1;
        end
    end

    // Flatten the RW registers onto the output bus.
    always_comb begin
        regs_out = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            regs_out[32*i +: 32] = regs[i];
        end
    end

    // Write-channel FSM: accept, then hold the response until BREADY.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state <= W_IDLE;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
        end else begin
            case (w_state)
                W_IDLE: if (wr_fire) begin
                    w_state <= W_RESP;
                    bvalid  <= 1'b1;
                    bresp   <= wr_map ? OKAY : SLVERR;
                end
                W_RESP: if (s_axi.S_AXI_BREADY) begin
                    w_state <= W_IDLE;
                    bvalid  <= 1'b0;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read-channel FSM: capture data/response at accept, hold until RREADY.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= R_IDLE;
            rvalid  <= 1'b0;
            rresp   <= OKAY;
            rdata   <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (rd_fire) begin
                    r_state <= R_DATA;
                    rvalid  <= 1'b1;
                    rdata   <= rd_word;
                    rresp   <= rd_ok ? OKAY : SLVERR;
                end
                R_DATA: if (s_axi.S_AXI_RREADY) begin
                    r_state <= R_IDLE;
                    rvalid  <= 1'b0;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Register file, W1C status with set-wins, enable word, registered IRQ.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            irq_status <= '0;
            irq_enable <= '0;
            Interrupt  <= 1'b0;
        end else begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (wr_fire && wr_idx == IW'(i)) begin
                    regs[i] <= (regs[i] & ~wmask) | wbits;
                end
            end
            if (wr_fire && wr_idx == EN_IDX) begin
                irq_enable <= (irq_enable & ~wmask[C_NUM_IRQ-1:0]) |
                              wbits[C_NUM_IRQ-1:0];
            end
            irq_status <= (irq_status & ~w1c) | irq_in;
            Interrupt  <= |(irq_status & irq_enable);
        end
    end
endmodule

// File: tb/tb_xillybus_lite_regbank.sv
// Directed bench for xillybus_lite_regbank.
// Hand-computed expectations; one checking task counts everything.
module tb_xillybus_lite_regbank;
    logic        clk;
    logic        rst_n;
    logic [3:0]  irq_in;
    logic [255:0] regs_out;
    logic        irq_o;
    int          total;
    int          bad;
    logic [1:0]  resp;
    logic [31:0] data;

    xillybus_lite_regbank_if #(.C_S_AXI_ADDR_WIDTH(32)) bus ();

    xillybus_lite_regbank dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .s_axi         (bus.slave),
        .irq_in        (irq_in),
        .regs_out      (regs_out),
        .Interrupt     (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic axi_wr(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [3:0] irq,
                          output logic [1:0] r);
        bit ok;
        r = 2'bxx;
        @(posedge clk); #1;
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_WSTRB   = s;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        irq_in            = irq;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.S_AXI_AWREADY && bus.S_AXI_WREADY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wr_accept_timeout", 0, 1);
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        irq_in            = '0;
        bus.S_AXI_BREADY  = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.S_AXI_BVALID) begin
                r  = bus.S_AXI_BRESP;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("bvalid_timeout", 0, 1);
        @(posedge clk); #1;
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_rd(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] r);
        bit ok;
        d = 'x;
        r = 2'bxx;
        @(posedge clk); #1;
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.S_AXI_ARREADY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("rd_accept_timeout", 0, 1);
        @(posedge clk); #1;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.S_AXI_RVALID) begin
                d  = bus.S_AXI_RDATA;
                r  = bus.S_AXI_RRESP;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("rvalid_timeout", 0, 1);
        @(posedge clk); #1;
        bus.S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        irq_in = '0;
        bus.S_AXI_AWADDR  = '0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = '0;
        bus.S_AXI_WSTRB   = '0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b0;
        bus.S_AXI_ARADDR  = '0;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bvalid", bus.S_AXI_BVALID, 0);
        chk("rst_rvalid", bus.S_AXI_RVALID, 0);
        chk("rst_rdata", bus.S_AXI_RDATA, 0);
        chk("rst_regs", regs_out[63:0], 0);
        chk("rst_irq", irq_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full-word write then read back.
        axi_wr(32'h04, 32'hA5A5_1234, 4'hF, 4'h0, resp);
        chk("t1_bresp", resp, 2'b00);
        axi_rd(32'h04, data, resp);
        chk("t1_rdata", data, 32'hA5A5_1234);
        chk("t1_rresp", resp, 2'b00);
        chk("t1_regs_out", regs_out[63:32], 32'hA5A5_1234);

        // Single byte lane write.
        axi_wr(32'h04, 32'hFFFF_FFFF, 4'hF, 4'h0, resp);
        axi_wr(32'h04, 32'h0000_0000, 4'b0010, 4'h0, resp);
        axi_rd(32'h04, data, resp);
        chk("t2_rdata", data, 32'hFFFF_00FF);

        // Empty strobe: OKAY, nothing changes.
        axi_wr(32'h04, 32'h1234_5678, 4'b0000, 4'h0, resp);
        chk("strb0_bresp", resp, 2'b00);
        axi_rd(32'h04, data, resp);
        chk("strb0_rdata", data, 32'hFFFF_00FF);

        // Address arrives three cycles ahead of data.
        @(posedge clk); #1;
        bus.S_AXI_AWADDR  = 32'h08;
        bus.S_AXI_WDATA   = 32'h0000_CAFE;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_AWVALID = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t3_awready_early", bus.S_AXI_AWREADY, 0);
            chk("t3_wready_early", bus.S_AXI_WREADY, 0);
            @(posedge clk); #1;
        end
        bus.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        chk("t3_awready", bus.S_AXI_AWREADY, 1);
        chk("t3_wready", bus.S_AXI_WREADY, 1);
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        @(negedge clk);
        chk("t3_awready_after", bus.S_AXI_AWREADY, 0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            chk("t3_bvalid_hold", bus.S_AXI_BVALID, 1);
            chk("t3_bresp_hold", bus.S_AXI_BRESP, 2'b00);
        end
        @(posedge clk); #1;
        bus.S_AXI_BREADY = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_BREADY = 1'b0;
        @(negedge clk);
        chk("t3_bvalid_drop", bus.S_AXI_BVALID, 0);
        axi_rd(32'h08, data, resp);
        chk("t3_rdata", data, 32'h0000_CAFE);

        // Unmapped accesses.
        axi_wr(32'h1FC, 32'hDEAD_BEEF, 4'hF, 4'h0, resp);
        chk("t5_bresp", resp, 2'b10);
        axi_rd(32'h1FC, data, resp);
        chk("t5_rdata", data, 0);
        chk("t5_rresp", resp, 2'b10);
        chk("t5_regs_lo", regs_out[95:0],
            {32'h0000_CAFE, 32'hFFFF_00FF, 32'h0});
        chk("t5_regs_hi", regs_out[255:96], 0);
        axi_rd(32'h28, data, resp);
        chk("idx10_rresp", resp, 2'b10);

        // Enable word only keeps implemented bits.
        axi_wr(32'h24, 32'hFFFF_FFFF, 4'hF, 4'h0, resp);
        axi_rd(32'h24, data, resp);
        chk("en_mask", data, 32'h0000_000F);
        axi_wr(32'h24, 32'h0000_0001, 4'hF, 4'h0, resp);

        // Interrupt path.
        @(posedge clk); #1;
        irq_in = 4'h1;
        @(posedge clk); #1;
        irq_in = 4'h0;
        @(negedge clk);
        chk("t4_irq_lat0", irq_o, 0);
        @(negedge clk);
        chk("t4_irq_rise", irq_o, 1);
        axi_wr(32'h20, 32'h1, 4'hF, 4'h1, resp);
        axi_rd(32'h20, data, resp);
        chk("t4_set_wins", data, 32'h1);
        chk("t4_irq_held", irq_o, 1);
        axi_wr(32'h20, 32'h1, 4'hF, 4'h0, resp);
        axi_rd(32'h20, data, resp);
        chk("t4_cleared", data, 32'h0);
        chk("t4_irq_fall", irq_o, 0);

        // Same-word read and write: read sees the old value.
        axi_wr(32'h00, 32'h77, 4'hF, 4'h0, resp);
        @(posedge clk); #1;
        irq_in = 4'h1;
        @(posedge clk); #1;
        irq_in = 4'h0;
        bus.S_AXI_AWADDR  = 32'h00;
        bus.S_AXI_WDATA   = 32'h55;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_ARADDR  = 32'h00;
        bus.S_AXI_ARVALID = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_ARVALID = 1'b0;
        @(negedge clk);
        chk("rw_rdata_old", bus.S_AXI_RDATA, 32'h77);
        chk("rw_reg_new", regs_out[31:0], 32'h55);
        chk("t6_pre_bvalid", bus.S_AXI_BVALID, 1);
        chk("t6_pre_rvalid", bus.S_AXI_RVALID, 1);
        chk("t6_pre_irq", irq_o, 1);

        // Asynchronous reset with both responses pending.
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_bvalid", bus.S_AXI_BVALID, 0);
        chk("t6_rvalid", bus.S_AXI_RVALID, 0);
        chk("t6_regs", regs_out[127:0], 0);
        chk("t6_irq", irq_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        axi_rd(32'h08, data, resp);
        chk("t6_reg2_after", data, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
